// File: rtl/cabac_se_intra_luma_order.sv
// rtl/cabac_se_intra_luma_order.sv - reorders per-PU intra luma syntax-element pairs into HEVC syntax order
//
// Collects one (2Nx2N) or four (NxN) PU word pairs {prev_intra_luma_pred_flag,
// mpm_idx/rem_intra_luma_pred_mode}, then emits all flag words followed by
// all mode words, in PU order.
//
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-high reset
//   start_i         - opens a CU (IDLE only); part_nxn_i sampled with it
//   pu_valid_i/pu_ready_o, flag_se_i, mode_se_i - per-PU input handshake
//   se_valid_o/se_ready_i, se_data_o            - output word handshake
//   busy_o          - not IDLE
//   done_o          - one-cycle pulse after the last word is accepted

module cabac_se_intra_luma_order #(
    parameter int SE_WIDTH = 21
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                part_nxn_i,
    input  logic                pu_valid_i,
    output logic                pu_ready_o,
    input  logic [SE_WIDTH-1:0] flag_se_i,
    input  logic [SE_WIDTH-1:0] mode_se_i,
    output logic                se_valid_o,
    input  logic                se_ready_i,
    output logic [SE_WIDTH-1:0] se_data_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_COLLECT   = 3'd1;
    localparam logic [2:0] S_EMIT_FLAG = 3'd2;
    localparam logic [2:0] S_EMIT_MODE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]          state;
    logic [1:0]          cnt;
    // 1 = NxN (four PUs), 0 = 2Nx2N (one PU)
    logic                num_pu;
    logic [SE_WIDTH-1:0] flag_buf [4];
    logic [SE_WIDTH-1:0] mode_buf [4];

    logic cnt_last;
    logic pu_fire;
    logic se_fire;

    assign cnt_last = num_pu ? (cnt == 2'd3) : (cnt == 2'd0);

    // Handshake outputs decode straight from state so reset clears them
    // asynchronously, without waiting for an edge.
    assign pu_ready_o = (state == S_COLLECT);
    assign se_valid_o = (state == S_EMIT_FLAG) || (state == S_EMIT_MODE);
    assign busy_o     = (state != S_IDLE);
    assign done_o     = (state == S_DONE);

    assign pu_fire = pu_valid_i && pu_ready_o;
    assign se_fire = se_valid_o && se_ready_i;

    // cnt only moves on acceptance, so the selected word holds under stall.
    always_comb begin
        se_data_o = '0;
        if (state == S_EMIT_FLAG) begin
            se_data_o = flag_buf[cnt];
        end else if (state == S_EMIT_MODE) begin
            se_data_o = mode_buf[cnt];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 2'd0;
            num_pu <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                flag_buf[i] <= '0;
                mode_buf[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        num_pu <= part_nxn_i;
                        cnt    <= 2'd0;
                        state  <= S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    if (pu_fire) begin
                        flag_buf[cnt] <= flag_se_i;
                        mode_buf[cnt] <= mode_se_i;
                        if (cnt_last) begin
                            cnt   <= 2'd0;
                            state <= S_EMIT_FLAG;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end

                S_EMIT_FLAG: begin
                    if (se_fire) begin
                        if (cnt_last) begin
                            cnt   <= 2'd0;
                            state <= S_EMIT_MODE;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end

                S_EMIT_MODE: begin
                    if (se_fire) begin
                        if (cnt_last) begin
                            cnt   <= 2'd0;
                            state <= S_DONE;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end

                S_DONE: begin
                    // A start in this cycle is deliberately dropped.
                    state <= S_IDLE;
                end

                default: begin
                    cnt   <= 2'd0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
